back_ground_flash_draw: RTL and testbench

BACK_GROUND_FLASH_DRAW -- requirements
Module: back_ground_flash_draw

---
 rtl/back_ground_pkg.sv | 21 ++
 rtl/frame_phase_counter.sv | 51 +++++
 rtl/back_ground_flash_draw.sv | 117 +++++++++++
 tb/tb_back_ground_flash_draw.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/back_ground_pkg.sv
// Shared types and constants for the flashing background/border renderer.
package back_ground_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlashHi,
    StFlashLo
  } flash_state_e;

  // RGB 3-3-2 colour constants
  localparam logic [7:0] RGB_BLACK = 8'h00;
  localparam logic [7:0] RGB_BLUE  = 8'h03;
  localparam logic [7:0] RGB_WHITE = 8'hFF;

  // Default frame geometry
  localparam int unsigned XFRAME_DEF = 640;
  localparam int unsigned YFRAME_DEF = 480;
  localparam int unsigned OFFSET_DEF = 32;
  localparam int unsigned THICK_DEF  = 2;

endpackage

// File: rtl/frame_phase_counter.sv
// Frame counter (per flash phase) and high/low pair counter with terminal-count flags.
module frame_phase_counter #(
  parameter int unsigned PERIOD_FRAMES = 8,
  parameter int unsigned FLASH_COUNT   = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic frame_tick,
  input  logic pair_inc,
  output logic frame_term,
  output logic pair_term
);

  localparam logic [7:0] FRAME_LAST = 8'(PERIOD_FRAMES - 1);
  localparam logic [3:0] PAIR_LAST  = 4'(FLASH_COUNT - 1);

  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] pair_cnt_q, pair_cnt_d;

  assign frame_term = (frame_cnt_q == FRAME_LAST);
  assign pair_term  = (pair_cnt_q == PAIR_LAST);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pair_cnt_d  = pair_cnt_q;
    if (clear) begin
      frame_cnt_d = '0;
      pair_cnt_d  = '0;
    end else begin
      if (frame_tick) begin
        frame_cnt_d = frame_term ? 8'd0 : frame_cnt_q + 8'd1;
      end
      // Saturate at the terminal value rather than wrapping
      if (pair_inc && !pair_term) begin
        pair_cnt_d = pair_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
      pair_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  end

endmodule

// File: rtl/back_ground_flash_draw.sv
// Background fill plus rectangular border that can flash for a fixed number of frames.
module back_ground_flash_draw
  import back_ground_pkg::*;
#(
  parameter int unsigned XFRAME        = XFRAME_DEF,
  parameter int unsigned YFRAME        = YFRAME_DEF,
  parameter int unsigned OFFSET        = OFFSET_DEF,
  parameter int unsigned THICK         = THICK_DEF,
  parameter logic [7:0]  BORDER_COLOR  = RGB_BLUE,
  parameter logic [7:0]  FLASH_COLOR   = RGB_WHITE,
  parameter logic [7:0]  FILL_COLOR    = RGB_BLACK,
  parameter int unsigned PERIOD_FRAMES = 8,
  parameter int unsigned FLASH_COUNT   = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        flashStart,
  output logic [7:0]  BG_RGB,
  output logic        boardersDrawReq,
  output logic        flashBusy,
  output logic        flashDone
);

  localparam logic [10:0] X_LO    = 11'(OFFSET);
  localparam logic [10:0] X_HI    = 11'(XFRAME - OFFSET);
  localparam logic [10:0] X_IN_LO = 11'(OFFSET + THICK);
  localparam logic [10:0] X_IN_HI = 11'(XFRAME - OFFSET - THICK);
  localparam logic [10:0] Y_LO    = 11'(OFFSET);
  localparam logic [10:0] Y_HI    = 11'(YFRAME - OFFSET);
  localparam logic [10:0] Y_IN_LO = 11'(OFFSET + THICK);
  localparam logic [10:0] Y_IN_HI = 11'(YFRAME - OFFSET - THICK);

  flash_state_e state_q, state_d;
  logic         flash_done_q, flash_done_d;
  logic [7:0]   bg_rgb_q, bg_rgb_d;
  logic         draw_req_q;
  logic         cnt_clear, frame_tick, pair_inc;
  logic         frame_term, pair_term;
  logic         in_rect, in_band, is_border;

  frame_phase_counter #(
    .PERIOD_FRAMES(PERIOD_FRAMES),
    .FLASH_COUNT  (FLASH_COUNT)
  ) u_frame_phase_counter (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (cnt_clear),
    .frame_tick(frame_tick),
    .pair_inc  (pair_inc),
    .frame_term(frame_term),
    .pair_term (pair_term)
  );

  always_comb begin
    state_d      = state_q;
    cnt_clear    = 1'b0;
    pair_inc     = 1'b0;
    flash_done_d = 1'b0;
    // A startOfFrame seen in idle never reaches the counter
    frame_tick   = startOfFrame && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (flashStart) begin
          state_d   = StFlashHi;
          cnt_clear = 1'b1;
        end
      end
      StFlashHi: begin
        if (startOfFrame && frame_term) state_d = StFlashLo;
      end
      StFlashLo: begin
        if (startOfFrame && frame_term) begin
          if (pair_term) begin
            state_d      = StIdle;
            flash_done_d = 1'b1;
          end else begin
            state_d  = StFlashHi;
            pair_inc = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_rect   = (pixelX >= X_LO) && (pixelX <= X_HI) && (pixelY >= Y_LO) && (pixelY <= Y_HI);
    in_band   = (pixelX < X_IN_LO) || (pixelX > X_IN_HI) ||
                (pixelY < Y_IN_LO) || (pixelY > Y_IN_HI);
    is_border = in_rect && in_band;
    bg_rgb_d  = FILL_COLOR;
    if (is_border) bg_rgb_d = (state_q == StFlashHi) ? FLASH_COLOR : BORDER_COLOR;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      flash_done_q <= 1'b0;
      bg_rgb_q     <= FILL_COLOR;
      draw_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flash_done_q <= flash_done_d;
      bg_rgb_q     <= bg_rgb_d;
      draw_req_q   <= is_border;
    end
  end

  assign BG_RGB          = bg_rgb_q;
  assign boardersDrawReq = draw_req_q;
  assign flashBusy       = (state_q != StIdle);
  assign flashDone       = flash_done_q;

endmodule

// File: tb/tb_back_ground_flash_draw.sv
// Directed bench for back_ground_flash_draw with default parameters.
module tb_back_ground_flash_draw;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, flashStart;
  logic [7:0]  BG_RGB;
  logic        boardersDrawReq, flashBusy, flashDone;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  back_ground_flash_draw dut (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .startOfFrame   (startOfFrame),
    .flashStart     (flashStart),
    .BG_RGB         (BG_RGB),
    .boardersDrawReq(boardersDrawReq),
    .flashBusy      (flashBusy),
    .flashDone      (flashDone)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input int exp_req, input int exp_rgb);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    check_val($sformatf("req(%0d,%0d)", x, y), int'(boardersDrawReq), exp_req);
    check_val($sformatf("rgb(%0d,%0d)", x, y), int'(BG_RGB), exp_rgb);
  endtask

  task automatic start_flash();
    flashStart = 1'b1;
    tick();
    flashStart = 1'b0;
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // Pulses frames until flashDone is seen; returns the number of frames pulsed
  task automatic count_frames(output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      pulse_sof();
      n++;
      if (flashDone) seen = 1'b1;
      tick();
    end
  endtask

  int n;

  initial begin
    resetN       = 1'b0;
    pixelX       = 11'd32;
    pixelY       = 11'd100;
    startOfFrame = 1'b0;
    flashStart   = 1'b0;
    tick();
    tick();
    check_val("rst_rgb", int'(BG_RGB), 'h00);
    check_val("rst_req", int'(boardersDrawReq), 0);
    check_val("rst_busy", int'(flashBusy), 0);
    check_val("rst_done", int'(flashDone), 0);
    resetN = 1'b1;

    // Border geometry in idle
    pixel(32, 100, 1, 'h03);
    pixel(33, 100, 1, 'h03);
    pixel(34, 100, 0, 'h00);
    pixel(31, 100, 0, 'h00);
    pixel(608, 448, 1, 'h03);
    pixel(607, 447, 1, 'h03);
    pixel(605, 445, 0, 'h00);
    pixel(609, 448, 0, 'h00);
    pixel(320, 33, 1, 'h03);
    pixel(320, 449, 0, 'h00);

    // Full flash sequence at a corner pixel
    pixelX = 11'd32;
    pixelY = 11'd32;
    tick();
    check_val("idle_corner_rgb", int'(BG_RGB), 'h03);
    start_flash();
    for (int f = 0; f < 64; f++) begin
      tick();
      check_val($sformatf("seq_rgb_f%0d", f), int'(BG_RGB), ((f / 8) % 2 == 0) ? 'hFF : 'h03);
      check_val($sformatf("seq_req_f%0d", f), int'(boardersDrawReq), 1);
      pulse_sof();
      check_val($sformatf("seq_done_f%0d", f), int'(flashDone), (f == 63) ? 1 : 0);
      check_val($sformatf("seq_busy_f%0d", f), int'(flashBusy), (f == 63) ? 0 : 1);
    end
    tick();
    check_val("done_one_cycle", int'(flashDone), 0);
    check_val("post_seq_rgb", int'(BG_RGB), 'h03);

    // Interior pixel stays fill colour during a flash-high phase
    start_flash();
    pixel(100, 100, 0, 'h00);
    count_frames(n);
    check_val("interior_seq_len", n, 64);

    // Restart request while busy is ignored
    start_flash();
    for (int f = 0; f < 3; f++) begin
      pulse_sof();
      tick();
    end
    start_flash();
    count_frames(n);
    check_val("restart_ignored_len", n + 3, 64);

    // flashStart coincident with startOfFrame
    flashStart   = 1'b1;
    startOfFrame = 1'b1;
    tick();
    flashStart   = 1'b0;
    startOfFrame = 1'b0;
    check_val("coinc_busy", int'(flashBusy), 1);
    count_frames(n);
    check_val("coinc_len", n, 64);

    // Reset in the middle of a sequence
    pixelX = 11'd32;
    pixelY = 11'd32;
    start_flash();
    for (int f = 0; f < 20; f++) begin
      pulse_sof();
      check_val($sformatf("pre_rst_done_f%0d", f), int'(flashDone), 0);
      tick();
    end
    check_val("pre_rst_rgb", int'(BG_RGB), 'hFF);
    resetN = 1'b0;
    #1;
    check_val("mid_rst_rgb", int'(BG_RGB), 'h00);
    check_val("mid_rst_req", int'(boardersDrawReq), 0);
    check_val("mid_rst_busy", int'(flashBusy), 0);
    check_val("mid_rst_done", int'(flashDone), 0);
    tick();
    resetN = 1'b1;
    tick();
    check_val("post_rst_busy", int'(flashBusy), 0);
    check_val("post_rst_done", int'(flashDone), 0);
    check_val("post_rst_rgb", int'(BG_RGB), 'h03);
    start_flash();
    count_frames(n);
    check_val("post_rst_len", n, 64);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
